// File: rtl/net_frame_pkg.sv
// Shared frame format for the node network: field widths, CRC-4 polynomial,
// transmitter state encoding and the serial CRC step used by both link ends.
package net_frame_pkg;

  localparam int ID_W             = 4;
  localparam int DATA_W           = 8;
  localparam int CRC_W            = 4;
  localparam int PAYLOAD_BITS     = 2 * ID_W + DATA_W;
  localparam int FRAME_BITS       = 22;
  localparam int CLKS_PER_BIT_DEF = 8;
  localparam logic [CRC_W-1:0] DEF_CRC_POLY = 4'h3;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_CRC   = 3'd3,
    TX_STOP  = 3'd4,
    TX_GAP   = 3'd5
  } tx_state_t;

  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b,
                                                 input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 accumulator, MSB-first, init zero; shared by transmitter and receiver.
module crc4_serial
  import net_frame_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_r;

  // CRC register: clear wins over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (clr) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (en) begin
      crc_r <= crc4_step(crc_r, bit_in, POLY);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: start, dest, src, data, CRC-4, stop, then an idle gap,
// each bit held CLKS_PER_BIT clocks on an idle-high line.
module frame_transmitter
  import net_frame_pkg::*;
#(
  parameter int               CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int               GAP_BITS     = 1,
  parameter logic [CRC_W-1:0] CRC_POLY     = DEF_CRC_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   node_id,
  input  logic [ID_W-1:0]   tx_dest,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              tx_done
);

  localparam logic [2:0] CYC_LAST      = 3'(CLKS_PER_BIT - 1);
  localparam logic [2:0] CYC_PENULT    = 3'(CLKS_PER_BIT - 2);
  localparam logic [4:0] DATA_BIT_LAST = 5'(PAYLOAD_BITS - 1);
  localparam logic [4:0] CRC_BIT_LAST  = 5'(CRC_W - 1);
  localparam logic [4:0] GAP_BIT_LAST  = 5'(GAP_BITS - 1);

  tx_state_t               state_r, state_nx_s;
  logic [2:0]              cyc_cnt_r, cyc_cnt_nx_s;
  logic [4:0]              bit_cnt_r, bit_cnt_nx_s;
  logic [PAYLOAD_BITS-1:0] shift_r, shift_nx_s;
  logic                    dout_r, dout_nx_s;
  logic                    tx_done_r, tx_done_nx_s;
  logic                    tx_ready_r, busy_r;
  logic                    accept_s, cyc_wrap_s;
  logic                    crc_clr_s, crc_en_s;
  logic [CRC_W-1:0]        crc_s;

  assign accept_s   = tx_valid && (state_r == TX_IDLE);
  assign cyc_wrap_s = (cyc_cnt_r == CYC_LAST);

  crc4_serial #(.POLY(CRC_POLY)) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr_s),
    .en     (crc_en_s),
    .bit_in (shift_r[PAYLOAD_BITS-1]),
    .crc    (crc_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= TX_IDLE;
      cyc_cnt_r  <= 3'd0;
      bit_cnt_r  <= 5'd0;
      shift_r    <= {PAYLOAD_BITS{1'b0}};
      dout_r     <= 1'b1;
      tx_done_r  <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cyc_cnt_r  <= cyc_cnt_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      shift_r    <= shift_nx_s;
      dout_r     <= dout_nx_s;
      tx_done_r  <= tx_done_nx_s;
      tx_ready_r <= (state_nx_s == TX_IDLE);
      busy_r     <= (state_nx_s != TX_IDLE);
    end
  end

  // Next state and counter sequencing
  always_comb begin
    state_nx_s   = state_r;
    cyc_cnt_nx_s = cyc_cnt_r + 3'd1;
    bit_cnt_nx_s = bit_cnt_r;
    case (state_r)
      TX_IDLE: begin
        cyc_cnt_nx_s = 3'd0;
        bit_cnt_nx_s = 5'd0;
        if (accept_s) begin
          state_nx_s = TX_START;
        end else begin
          state_nx_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (cyc_wrap_s) begin
          state_nx_s   = TX_DATA;
          bit_cnt_nx_s = 5'd0;
        end else begin
          state_nx_s = TX_START;
        end
      end
      TX_DATA: begin
        if (cyc_wrap_s && (bit_cnt_r == DATA_BIT_LAST)) begin
          state_nx_s   = TX_CRC;
          bit_cnt_nx_s = 5'd0;
        end else if (cyc_wrap_s) begin
          bit_cnt_nx_s = bit_cnt_r + 5'd1;
        end else begin
          bit_cnt_nx_s = bit_cnt_r;
        end
      end
      TX_CRC: begin
        if (cyc_wrap_s && (bit_cnt_r == CRC_BIT_LAST)) begin
          state_nx_s   = TX_STOP;
          bit_cnt_nx_s = 5'd0;
        end else if (cyc_wrap_s) begin
          bit_cnt_nx_s = bit_cnt_r + 5'd1;
        end else begin
          bit_cnt_nx_s = bit_cnt_r;
        end
      end
      TX_STOP: begin
        if (cyc_wrap_s) begin
          state_nx_s   = (GAP_BITS == 0) ? TX_IDLE : TX_GAP;
          bit_cnt_nx_s = 5'd0;
        end else begin
          state_nx_s = TX_STOP;
        end
      end
      // The IDLE cycle that precedes acceptance is the last gap clock, so the
      // gap state itself ends one cycle early to keep start bits evenly spaced.
      TX_GAP: begin
        if ((cyc_cnt_r == CYC_PENULT) && (bit_cnt_r == GAP_BIT_LAST)) begin
          state_nx_s   = TX_IDLE;
          cyc_cnt_nx_s = 3'd0;
          bit_cnt_nx_s = 5'd0;
        end else if (cyc_wrap_s) begin
          bit_cnt_nx_s = bit_cnt_r + 5'd1;
        end else begin
          bit_cnt_nx_s = bit_cnt_r;
        end
      end
      default: begin
        state_nx_s   = TX_IDLE;
        cyc_cnt_nx_s = 3'd0;
        bit_cnt_nx_s = 5'd0;
      end
    endcase
  end

  // Line value, shift register and CRC control; dout only moves on bit boundaries
  always_comb begin
    dout_nx_s    = dout_r;
    shift_nx_s   = shift_r;
    tx_done_nx_s = 1'b0;
    crc_clr_s    = 1'b0;
    crc_en_s     = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (accept_s) begin
          dout_nx_s  = 1'b0;
          shift_nx_s = {tx_dest, node_id, tx_data};
          crc_clr_s  = 1'b1;
        end else begin
          dout_nx_s = 1'b1;
        end
      end
      TX_START: begin
        if (cyc_wrap_s) begin
          dout_nx_s  = shift_r[PAYLOAD_BITS-1];
          shift_nx_s = {shift_r[PAYLOAD_BITS-2:0], 1'b0};
          crc_en_s   = 1'b1;
        end else begin
          dout_nx_s = dout_r;
        end
      end
      TX_DATA: begin
        if (cyc_wrap_s && (bit_cnt_r == DATA_BIT_LAST)) begin
          dout_nx_s  = crc_s[CRC_W-1];
          shift_nx_s = {crc_s[CRC_W-2:0], {(PAYLOAD_BITS-CRC_W+1){1'b0}}};
        end else if (cyc_wrap_s) begin
          dout_nx_s  = shift_r[PAYLOAD_BITS-1];
          shift_nx_s = {shift_r[PAYLOAD_BITS-2:0], 1'b0};
          crc_en_s   = 1'b1;
        end else begin
          dout_nx_s = dout_r;
        end
      end
      TX_CRC: begin
        if (cyc_wrap_s && (bit_cnt_r == CRC_BIT_LAST)) begin
          dout_nx_s = 1'b1;
        end else if (cyc_wrap_s) begin
          dout_nx_s  = shift_r[PAYLOAD_BITS-1];
          shift_nx_s = {shift_r[PAYLOAD_BITS-2:0], 1'b0};
        end else begin
          dout_nx_s = dout_r;
        end
      end
      TX_STOP: begin
        dout_nx_s    = 1'b1;
        tx_done_nx_s = (cyc_cnt_r == CYC_PENULT);
      end
      TX_GAP: begin
        dout_nx_s = 1'b1;
      end
      default: begin
        dout_nx_s = 1'b1;
      end
    endcase
  end

  assign dout     = dout_r;
  assign tx_done  = tx_done_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: idle/reset state, frame content and timing,
// all-zero frame, back-to-back spacing with input changes, and reset mid-frame.
module tb_frame_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] node_id;
  logic [3:0] tx_dest;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       dout;
  logic       busy;
  logic       tx_done;

  int errors = 0;
  int checks = 0;

  localparam logic [21:0] FRAME_A    = {1'b0, 4'h5, 4'hA, 8'h3C, 4'hE, 1'b1};
  localparam logic [21:0] FRAME_B    = {1'b0, 4'hF, 4'h3, 8'hA5, 4'h4, 1'b1};
  localparam logic [21:0] FRAME_ZERO = {1'b0, 20'h00000, 1'b1};

  frame_transmitter dut (
    .clk      (clk),
    .rst      (rst),
    .node_id  (node_id),
    .tx_dest  (tx_dest),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
    end
  endtask

  // Offer one message, scramble the inputs right after acceptance, sample each bit at cycle 3
  task automatic send_capture(input logic [3:0] nid, input logic [3:0] dst, input logic [7:0] data,
                              output logic [21:0] bits, output int done_c, output int done_n,
                              output int ready_c, output logic busy_mid, output logic busy_end);
    wait_ready();
    node_id  = nid;
    tx_dest  = dst;
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    node_id  = ~nid;
    tx_dest  = ~dst;
    tx_data  = ~data;
    bits     = '0;
    done_c   = -1;
    done_n   = 0;
    ready_c  = -1;
    busy_mid = 1'b0;
    busy_end = 1'b1;
    for (int c = 0; c < 192; c++) begin
      @(negedge clk);
      if (c < 176 && (c % 8) == 3) bits[21 - c / 8] = dout;
      if (tx_done === 1'b1) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (tx_ready === 1'b1 && ready_c < 0) ready_c = c;
      if (c == 100) busy_mid = busy;
      if (c == 183) busy_end = busy;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    node_id  = 4'h0;
    tx_dest  = 4'h0;
    tx_data  = 8'h00;
    #2;
    checks++;
    if ({dout, tx_ready, busy, tx_done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_state: dout/ready/busy/done=%b required 1100", {dout, tx_ready, busy, tx_done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if ({dout, tx_ready, busy, tx_done} !== 4'b1100) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: dout/ready/busy/done=%b required 1100", c,
                 {dout, tx_ready, busy, tx_done});
      end
    end
  endtask

  task automatic test_frame_a();
    logic [21:0] bits;
    int dc, dn, rc;
    logic bm, be;
    send_capture(4'hA, 4'h5, 8'h3C, bits, dc, dn, rc, bm, be);
    checks++;
    if (bits !== FRAME_A) begin
      errors++;
      $display("FAIL frame_a_bits: got %b required %b", bits, FRAME_A);
    end
    checks++;
    if (dc !== 175) begin
      errors++;
      $display("FAIL frame_a_done_time: tx_done at cycle %0d required 175", dc);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL frame_a_done_width: %0d tx_done cycles required 1", dn);
    end
    checks++;
    if (rc !== 183) begin
      errors++;
      $display("FAIL frame_a_ready_time: tx_ready at cycle %0d required 183", rc);
    end
    checks++;
    if ({bm, be} !== 2'b10) begin
      errors++;
      $display("FAIL frame_a_busy: busy mid/end=%b required 10", {bm, be});
    end
  endtask

  task automatic test_zero_frame();
    logic [21:0] bits;
    int dc, dn, rc;
    logic bm, be;
    send_capture(4'h0, 4'h0, 8'h00, bits, dc, dn, rc, bm, be);
    checks++;
    if (bits !== FRAME_ZERO) begin
      errors++;
      $display("FAIL zero_frame_bits: got %b required %b", bits, FRAME_ZERO);
    end
    checks++;
    if (dc !== 175) begin
      errors++;
      $display("FAIL zero_frame_done_time: tx_done at cycle %0d required 175", dc);
    end
  endtask

  task automatic test_back_to_back();
    logic d [0:375];
    logic [21:0] f1, f2;
    int rdy_c [0:1];
    int rdy_n;
    logic rdy;
    rdy_c[0] = -1;
    rdy_c[1] = -1;
    rdy_n    = 0;
    wait_ready();
    node_id  = 4'hA;
    tx_dest  = 4'h5;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    node_id = 4'h3;
    tx_dest = 4'hF;
    tx_data = 8'hA5;
    for (int c = 0; c < 376; c++) begin
      @(negedge clk);
      d[c] = dout;
      rdy  = (tx_ready === 1'b1);
      if (rdy && rdy_n < 2) begin
        rdy_c[rdy_n] = c;
        rdy_n++;
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        node_id = 4'hA;
        tx_dest = 4'h5;
        tx_data = 8'h3C;
      end
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      f1[21 - i] = d[8 * i + 3];
      f2[21 - i] = d[184 + 8 * i + 3];
    end
    checks++;
    if (f1 !== FRAME_A) begin
      errors++;
      $display("FAIL b2b_frame1: got %b required %b", f1, FRAME_A);
    end
    checks++;
    if (f2 !== FRAME_B) begin
      errors++;
      $display("FAIL b2b_frame2: got %b required %b", f2, FRAME_B);
    end
    checks++;
    if (rdy_c[0] !== 183 || rdy_c[1] !== 367) begin
      errors++;
      $display("FAIL b2b_ready_times: got %0d,%0d required 183,367", rdy_c[0], rdy_c[1]);
    end
    checks++;
    if ({d[183], d[184], d[367], d[368]} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_start_spacing: dout at 183/184/367/368=%b required 1010",
               {d[183], d[184], d[367], d[368]});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [21:0] bits;
    int dc, dn, rc;
    logic bm, be;
    wait_ready();
    node_id  = 4'h0;
    tx_dest  = 4'h6;
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int c = 0; c < 61; c++) @(negedge clk);
    checks++;
    if (dout !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_bit: dout=%b at cycle 60 required 0", dout);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, tx_ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL async_reset: dout/ready/busy=%b required 110", {dout, tx_ready, busy});
    end
    #2;
    rst = 1'b0;
    send_capture(4'hA, 4'h5, 8'h3C, bits, dc, dn, rc, bm, be);
    checks++;
    if (bits !== FRAME_A) begin
      errors++;
      $display("FAIL post_reset_frame: got %b required %b", bits, FRAME_A);
    end
    checks++;
    if (dc !== 175 || dn !== 1) begin
      errors++;
      $display("FAIL post_reset_done: first at %0d count %0d required 175 and 1", dc, dn);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_zero_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
